// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - pipeline/hazard-unit signal bundle; HAZARD_STATS_EN adds stall/flush counters
interface hazard_control_unit_if;
    logic       ID_EX_mem_read;
    logic [4:0] ID_EX_rt;
    logic [4:0] IF_ID_rs;
    logic [4:0] IF_ID_rt;
    logic       IF_ID_uses_rt;
    logic       branch_taken;
    logic       jump;
    logic       pc_write;
    logic       IF_ID_write;
    logic       IF_ID_flush;
    logic       ctrl_sel;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count;
    logic [15:0] flush_count;
`endif

    modport master (
        output ID_EX_mem_read, ID_EX_rt, IF_ID_rs, IF_ID_rt, IF_ID_uses_rt,
        output branch_taken, jump,
        input  pc_write, IF_ID_write, IF_ID_flush, ctrl_sel
`ifdef HAZARD_STATS_EN
        , input stall_count, flush_count
`endif
    );

    modport slave (
        input  ID_EX_mem_read, ID_EX_rt, IF_ID_rs, IF_ID_rt, IF_ID_uses_rt,
        input  branch_taken, jump,
        output pc_write, IF_ID_write, IF_ID_flush, ctrl_sel
`ifdef HAZARD_STATS_EN
        , output stall_count, flush_count
`endif
    );
endinterface

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use stall / branch flush controller; optional HAZARD_STATS_EN counters
module hazard_control_unit #(
    parameter int LOAD_STALLS  = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    hazard_control_unit_if.slave    hz
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_STALLS - 1);
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load_use;
    logic             redirect;
    logic             enable;
    logic             flush;

    // $0 is hard-wired zero, so a load targeting it can never create a dependency
    always_comb begin
        load_use = hz.ID_EX_mem_read && (hz.ID_EX_rt != 5'd0) &&
                   ((hz.ID_EX_rt == hz.IF_ID_rs) ||
                    (hz.IF_ID_uses_rt && (hz.ID_EX_rt == hz.IF_ID_rt)));
        redirect = hz.branch_taken || hz.jump;
    end

    // Mealy outputs; a load-use in RUN beats redirect since branch operands are stale
    always_comb begin
        enable = 1'b0;
        flush  = 1'b0;
        if (rst) begin
            case (state)
                RUN: begin
                    enable = !load_use;
                    flush  = !load_use && redirect;
                end
                STALL: begin
                    enable = 1'b0;
                    flush  = 1'b0;
                end
                FLUSH: begin
                    enable = 1'b1;
                    flush  = 1'b1;
                end
                default: begin
                    enable = 1'b0;
                    flush  = 1'b0;
                end
            endcase
        end
    end

    assign hz.pc_write    = enable;
    assign hz.IF_ID_write = enable;
    assign hz.ctrl_sel    = enable;
    assign hz.IF_ID_flush = flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        if (LOAD_STALLS > 1) begin
                            state <= STALL;
                            cnt   <= STALL_RELOAD;
                        end
                    end else if (redirect) begin
                        if (FLUSH_CYCLES > 1) begin
                            state <= FLUSH;
                            cnt   <= FLUSH_RELOAD;
                        end
                    end
                end
                STALL, FLUSH: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hz.stall_count <= '0;
            hz.flush_count <= '0;
        end else begin
            if (!enable && (hz.stall_count != 16'hFFFF)) begin
                hz.stall_count <= hz.stall_count + 16'd1;
            end
            if (flush && (hz.flush_count != 16'hFFFF)) begin
                hz.flush_count <= hz.flush_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - bench for hazard_control_unit (default and 3-stall/2-flush builds)
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_read;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       br;
    logic       jmp;

    int checks   = 0;
    int failures = 0;
    int sl_d = 0, fl_d = 0, sl_3 = 0, fl_3 = 0;
    int exp_stall_cnt = 0, exp_flush_cnt = 0;

    always #5 clk = ~clk;

    hazard_control_unit_if hz_def ();
    hazard_control_unit_if hz_ls3 ();

    assign hz_def.ID_EX_mem_read = mem_read;
    assign hz_def.ID_EX_rt       = ex_rt;
    assign hz_def.IF_ID_rs       = rs;
    assign hz_def.IF_ID_rt       = rt;
    assign hz_def.IF_ID_uses_rt  = uses_rt;
    assign hz_def.branch_taken   = br;
    assign hz_def.jump           = jmp;
    assign hz_ls3.ID_EX_mem_read = mem_read;
    assign hz_ls3.ID_EX_rt       = ex_rt;
    assign hz_ls3.IF_ID_rs       = rs;
    assign hz_ls3.IF_ID_rt       = rt;
    assign hz_ls3.IF_ID_uses_rt  = uses_rt;
    assign hz_ls3.branch_taken   = br;
    assign hz_ls3.jump           = jmp;

    hazard_control_unit #(.LOAD_STALLS(1), .FLUSH_CYCLES(1), .CNT_W(3)) u_def (
        .clk (clk),
        .rst (rst_n),
        .hz  (hz_def.slave)
    );

    hazard_control_unit #(.LOAD_STALLS(3), .FLUSH_CYCLES(2), .CNT_W(3)) u_ls3 (
        .clk (clk),
        .rst (rst_n),
        .hz  (hz_ls3.slave)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Remaining-cycle countdowns: how many more bubble/flush cycles follow this one
    task automatic model(input int ls, input int fc, input logic lu, input logic rd,
                         inout int stall_left, inout int flush_left,
                         output logic en, output logic fl);
        if (!rst_n) begin
            stall_left = 0; flush_left = 0; en = 1'b0; fl = 1'b0;
        end else if (stall_left > 0) begin
            en = 1'b0; fl = 1'b0; stall_left--;
        end else if (flush_left > 0) begin
            en = 1'b1; fl = 1'b1; flush_left--;
        end else if (lu) begin
            en = 1'b0; fl = 1'b0; stall_left = ls - 1;
        end else if (rd) begin
            en = 1'b1; fl = 1'b1; flush_left = fc - 1;
        end else begin
            en = 1'b1; fl = 1'b0;
        end
    endtask

    task automatic step();
        logic lu, rd, en, fl;
        @(negedge clk);
        lu = mem_read && (ex_rt != 5'd0) && ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
        rd = br || jmp;
        model(1, 1, lu, rd, sl_d, fl_d, en, fl);
        chk("def_pc_write",    hz_def.pc_write,    en);
        chk("def_IF_ID_write", hz_def.IF_ID_write, en);
        chk("def_ctrl_sel",    hz_def.ctrl_sel,    en);
        chk("def_IF_ID_flush", hz_def.IF_ID_flush, fl);
        if (!rst_n) begin
            exp_stall_cnt = 0; exp_flush_cnt = 0;
        end else begin
            if (!en && exp_stall_cnt < 16'hFFFF) exp_stall_cnt++;
            if (fl && exp_flush_cnt < 16'hFFFF) exp_flush_cnt++;
        end
        model(3, 2, lu, rd, sl_3, fl_3, en, fl);
        chk("ls3_pc_write",    hz_ls3.pc_write,    en);
        chk("ls3_IF_ID_write", hz_ls3.IF_ID_write, en);
        chk("ls3_ctrl_sel",    hz_ls3.ctrl_sel,    en);
        chk("ls3_IF_ID_flush", hz_ls3.IF_ID_flush, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_read = 1'b0; ex_rt = 5'd0; rs = 5'd0; rt = 5'd0;
        uses_rt = 1'b0; br = 1'b0; jmp = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        step();
        step();
        rst_n = 1'b1;
        step();

        // load-use on rs
        mem_read = 1'b1; ex_rt = 5'd8; rs = 5'd8;
        step();
        idle();
        repeat (3) step();

        // $0 never hazards; rt ignored when not read
        mem_read = 1'b1; ex_rt = 5'd0; rs = 5'd0;
        step();
        ex_rt = 5'd9; rt = 5'd9; rs = 5'd1; uses_rt = 1'b0;
        step();
        uses_rt = 1'b1;
        step();
        idle();
        repeat (3) step();

        // stall then branch during second bubble
        mem_read = 1'b1; ex_rt = 5'd5; rs = 5'd5;
        step();
        idle(); br = 1'b1;
        step();
        br = 1'b0;
        repeat (3) step();

        // jump
        jmp = 1'b1;
        step();
        jmp = 1'b0;
        repeat (3) step();

        // simultaneous load-use and branch
        mem_read = 1'b1; ex_rt = 5'd7; rt = 5'd7; uses_rt = 1'b1; rs = 5'd2; br = 1'b1;
        step();
        idle();
        repeat (4) step();

        // reset during second stall cycle
        mem_read = 1'b1; ex_rt = 5'd3; rs = 5'd3;
        step();
        idle(); rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            mem_read = ($urandom_range(0, 1) == 1);
            ex_rt    = 5'($urandom_range(0, 3));
            rs       = 5'($urandom_range(0, 3));
            rt       = 5'($urandom_range(0, 3));
            uses_rt  = ($urandom_range(0, 1) == 1);
            br       = ($urandom_range(0, 4) == 0);
            jmp      = ($urandom_range(0, 9) == 0);
            rst_n    = ($urandom_range(0, 39) != 0);
            step();
        end
        idle();
        rst_n = 1'b1;
        repeat (4) step();

`ifdef HAZARD_STATS_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk16("stats_reset_stall", hz_def.stall_count, 16'd0);
        mem_read = 1'b1; ex_rt = 5'd4; rs = 5'd4;
        step();
        idle();
        step();
        mem_read = 1'b1; ex_rt = 5'd6; rt = 5'd6; uses_rt = 1'b1;
        step();
        idle();
        step();
        jmp = 1'b1;
        step();
        jmp = 1'b0;
        step();
        chk16("stats_stall_2", hz_def.stall_count, 16'd2);
        chk16("stats_flush_1", hz_def.flush_count, 16'd1);
        chk16("stats_stall_model", hz_def.stall_count, 16'(exp_stall_cnt));
        mem_read = 1'b1; ex_rt = 5'd4; rs = 5'd4;
        for (int i = 0; i < 70000; i++) step();
        idle();
        step();
        chk16("stats_stall_sat", hz_def.stall_count, 16'hFFFF);
        chk16("stats_flush_model", hz_def.flush_count, 16'(exp_flush_cnt));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
